// File: rtl/btn_debounce_pkg.sv
// Shared constants and helpers for the push-button conditioning block:
// default debounce/long-press periods per clock rate and a counter-width helper.
package btn_debounce_pkg;

  // 25 MHz board oscillator: 10 ms debounce, 0.5 s long press
  localparam int DEB_CYCLES_25M  = 250_000;
  localparam int LONG_CYCLES_25M = 12_500_000;

  // 100 MHz PLL clock: 10 ms debounce, 0.5 s long press
  localparam int DEB_CYCLES_PLL  = 1_000_000;
  localparam int LONG_CYCLES_PLL = 50_000_000;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button: optional inversion, 2-FF synchroniser, counter debounce,
// press/release strobes and a saturating hold counter for the long-press strobe.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEB_CYCLES_PLL,
  parameter int   LONG_CYCLES     = LONG_CYCLES_PLL,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic state,
  output logic press,
  output logic rel,
  output logic long_press,
  output logic press_nxt
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic          flip;

  // The new level has persisted long enough: accept it on this edge.
  assign flip      = (s2 != state) && (dcnt == D_LAST);
  assign press_nxt = flip & s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= 1'b0;
      dcnt  <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= pin ^ INVERT;
      s2    <= s1;
      press <= press_nxt;
      rel   <= flip & ~s2;
      if (s2 == state) begin
        dcnt <= '0;
      end else if (flip) begin
        state <= s2;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  if (LONG_CYCLES > 0) begin : g_long
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hcnt;

    // Saturating at H_MAX guarantees one long strobe per press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt       <= '0;
        long_press <= 1'b0;
      end else begin
        long_press <= state && (hcnt == H_LAST);
        if (!state) begin
          hcnt <= '0;
        end else if (hcnt != H_MAX) begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end else begin : g_no_long
    assign long_press = 1'b0;
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning for the board buttons: NUM_BTN independent
// debounce channels plus a registered any_press aligned with btn_press.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int                 NUM_BTN         = 7,
  parameter logic [NUM_BTN-1:0] BTN_INVERT      = NUM_BTN'(1),
  parameter int                 DEBOUNCE_CYCLES = DEB_CYCLES_PLL,
  parameter int                 LONG_CYCLES     = LONG_CYCLES_PLL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               any_press
);

  logic [NUM_BTN-1:0] press_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .INVERT         (BTN_INVERT[i])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin       (btn[i]),
      .state     (btn_state[i]),
      .press     (btn_press[i]),
      .rel       (btn_release[i]),
      .long_press(btn_long[i]),
      .press_nxt (press_nxt[i])
    );
  end

  // Built from the channels' next-press terms so it lands on the same edge as btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_nxt;
    end
  end

endmodule
